// File: rtl/gf233_pkg.sv
// rtl/gf233_pkg.sv - shared constants, state encoding and squaring helper for the GF(2^233) sqrt unit
package gf233_pkg;

    localparam int M              = 233;
    localparam int TAP_HI         = 233;
    localparam int TAP_MID        = 74;
    localparam int TAP_LO         = 0;
    localparam int SQ_PER_CYC_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic bit sq_per_cyc_legal(input int n);
        return (n == 1) || (n == 2) || (n == 4) || (n == 8) || (n == 29);
    endfunction

    function automatic int iter_of(input int n);
        return (M - 1) / n;
    endfunction

    // Spread a into even bit positions, then fold x^k (k >= 233) onto x^(k-159) + x^(k-233),
    // walking downwards so the second-level overflow above x^232 is folded again.
    function automatic logic [M-1:0] gf_sq(input logic [M-1:0] a);
        logic [2*M-2:0] c;
        c = '0;
        for (int i = 0; i < M; i++) begin
            c[2*i] = a[i];
        end
        for (int k = 2*M-2; k >= TAP_HI; k--) begin
            if (c[k]) begin
                c[k - TAP_HI + TAP_MID] = ~c[k - TAP_HI + TAP_MID];
                c[k - TAP_HI + TAP_LO]  = ~c[k - TAP_HI + TAP_LO];
                c[k]                    = 1'b0;
            end
        end
        return c[M-1:0];
    endfunction

endpackage

// File: rtl/gf233_sq.sv
// rtl/gf233_sq.sv - single combinational squaring mod x^233 + x^74 + 1
module gf233_sq
    import gf233_pkg::*;
(
    input  logic [M-1:0] i_din,
    output logic [M-1:0] o_dout
);

    assign o_dout = gf_sq(i_din);

endmodule

// File: rtl/gf233_sq_chain.sv
// rtl/gf233_sq_chain.sv - N squaring blocks in series, computes din^(2^N)
module gf233_sq_chain
    import gf233_pkg::*;
#(
    parameter int N = SQ_PER_CYC_DEF
)
(
    input  logic [M-1:0] i_din,
    output logic [M-1:0] o_dout
);

    logic [M-1:0] w_stage [0:N];

    assign w_stage[0] = i_din;

    for (genvar g = 0; g < N; g++) begin : g_sq
        gf233_sq u_sq (
            .i_din  (w_stage[g]),
            .o_dout (w_stage[g+1])
        );
    end

    assign o_dout = w_stage[N];

endmodule

// File: rtl/gf233_sqrt.sv
// rtl/gf233_sqrt.sv - multi-cycle square root over GF(2^233) as a^(2^232) with start/done handshake
module gf233_sqrt
    import gf233_pkg::*;
#(
    parameter int SQ_PER_CYC = SQ_PER_CYC_DEF
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] din,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] dout
);

    localparam int ITER = iter_of(SQ_PER_CYC);
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    if (!sq_per_cyc_legal(SQ_PER_CYC)) begin : g_bad_param
        $error("gf233_sqrt: SQ_PER_CYC must be one of 1, 2, 4, 8, 29");
    end

    state_t          r_state;
    state_t          w_state_nxt;
    logic [M-1:0]    r_acc;
    logic [M-1:0]    w_acc_nxt;
    logic [M-1:0]    w_acc_sq;
    logic [M-1:0]    r_dout;
    logic [M-1:0]    w_dout_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            r_busy;
    logic            w_busy_nxt;
    logic            r_done;
    logic            w_done_nxt;
    logic            w_last;

    gf233_sq_chain #(.N(SQ_PER_CYC)) u_chain (
        .i_din  (r_acc),
        .o_dout (w_acc_sq)
    );

    assign w_last = (r_cnt == CW'(ITER - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_IDLE;
            default:             w_state_nxt = ST_IDLE;
        endcase
    end

    // done defaults low so it is a single-cycle pulse on the completion edge only
    always_comb begin
        w_acc_nxt  = r_acc;
        w_cnt_nxt  = r_cnt;
        w_dout_nxt = r_dout;
        w_busy_nxt = r_busy;
        w_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_acc_nxt  = din;
                    w_cnt_nxt  = '0;
                    w_busy_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                w_acc_nxt = w_acc_sq;
                if (w_last) begin
                    w_cnt_nxt  = '0;
                    w_dout_nxt = w_acc_sq;
                    w_done_nxt = 1'b1;
                    w_busy_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_dout <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_acc  <= w_acc_nxt;
            r_cnt  <= w_cnt_nxt;
            r_dout <= w_dout_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign dout = r_dout;

endmodule

// File: tb/tb_gf233_sqrt.sv
// tb/tb_gf233_sqrt.sv - self-checking scoreboard bench for gf233_sqrt
module tb_gf233_sqrt;

    localparam int MW   = 233;
    localparam int SQ   = 8;
    localparam int ITER = 232 / SQ;
    localparam int LBND = 4 * ITER + 20;
    localparam int NR   = 150;

    typedef struct {
        logic [MW-1:0] val;
        bit            sq_chk;
    } sb_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [MW-1:0] din;
    logic          busy;
    logic          done;
    logic [MW-1:0] dout;

    int  n_tests;
    int  n_fail;
    sb_t sb_q[$];
    sb_t mon_e;

    gf233_sqrt #(.SQ_PER_CYC(SQ)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // multiply by x, then shift-and-add, independent of the bit-spread reduction
    function automatic logic [MW-1:0] model_mul(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [MW-1:0] r;
        logic          carry;
        r = '0;
        for (int i = MW - 1; i >= 0; i--) begin
            carry = r[MW-1];
            r     = r << 1;
            if (carry) begin
                r[74] = ~r[74];
                r[0]  = ~r[0];
            end
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    function automatic logic [MW-1:0] model_sq(input logic [MW-1:0] a);
        return model_mul(a, a);
    endfunction

    function automatic logic [MW-1:0] model_sqrt(input logic [MW-1:0] a);
        logic [MW-1:0] r;
        r = a;
        for (int i = 0; i < 232; i++) r = model_sq(r);
        return r;
    endfunction

    function automatic logic [MW-1:0] rand233();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
        return t[MW-1:0];
    endfunction

    function automatic sb_t mk(input logic [MW-1:0] v, input bit s);
        sb_t e;
        e.val    = v;
        e.sq_chk = s;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            chk("done_expected", {232'b0, (sb_q.size() != 0)}, 1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                if (mon_e.sq_chk) chk("sqrt_squared", model_sq(dout), mon_e.val);
                else              chk("dout", dout, mon_e.val);
            end
        end
    end

    task automatic do_op(input logic [MW-1:0] a, input bit chk_lat);
        int lat;
        int bc;
        @(negedge clk);
        din   = a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        bc    = 0;
        while (!done && lat < LBND) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
        if (chk_lat || lat >= LBND) chk("latency", lat, ITER + 1);
        if (chk_lat) chk("busy_cycles", bc, ITER);
        @(negedge clk);
        if (chk_lat) chk("done_pulse_width", {232'b0, done}, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [MW-1:0] a;
        logic [MW-1:0] pat;
        logic [MW-1:0] sqrt_x;
        int            n;

        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        din     = '0;
        sqrt_x  = model_sqrt(233'd2);
        repeat (3) @(negedge clk);
        chk("rst_busy", {232'b0, busy}, 0);
        chk("rst_done", {232'b0, done}, 0);
        chk("rst_dout", dout, 0);
        rst = 1'b0;

        sb_q.push_back(mk(233'd2, 1'b0));
        do_op(233'd4, 1'b1);
        sb_q.push_back(mk(233'd4, 1'b0));
        do_op(233'd16, 1'b1);
        sb_q.push_back(mk(233'd0, 1'b0));
        do_op(233'd0, 1'b1);
        sb_q.push_back(mk(233'd1, 1'b0));
        do_op(233'd1, 1'b1);

        pat = 233'({8{32'h5A5A5A5A}});
        @(negedge clk);
        din   = pat;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {232'b0, busy}, 0);
        chk("abort_done", {232'b0, done}, 0);
        chk("abort_dout", dout, 0);
        repeat (ITER + 5) @(negedge clk);
        sb_q.push_back(mk(233'd1, 1'b0));
        do_op(233'd1, 1'b1);

        a = rand233();
        sb_q.push_back(mk(a, 1'b0));
        @(negedge clk);
        din   = model_sq(a);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        din   = rand233();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < LBND) begin
            @(negedge clk);
            n++;
        end
        chk("ignored_start_lat", n, ITER - 6);
        repeat (ITER + 5) @(negedge clk);
        chk("ignored_start_hold", dout, a);

        sb_q.push_back(mk(sqrt_x, 1'b0));
        sb_q.push_back(mk(233'd2, 1'b0));
        sb_q.push_back(mk(233'd4, 1'b0));
        @(negedge clk);
        din   = 233'd2;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done && n < LBND);
            chk("held_spacing", n, ITER + 1);
            if (k == 0)      din   = 233'd4;
            else if (k == 1) din   = 233'd16;
            else             start = 1'b0;
        end
        repeat (ITER + 5) @(negedge clk);

        for (int i = 0; i < NR; i++) begin
            a = rand233();
            sb_q.push_back(mk(a, 1'b0));
            do_op(model_sq(a), 1'b0);
        end
        for (int i = 0; i < NR; i++) begin
            a = rand233();
            sb_q.push_back(mk(a, 1'b1));
            do_op(a, 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("sb_drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gf233_sqrt.md
Name: gf233_sqrt

Overview:
- Multi-cycle square-root unit over GF(2^233), polynomial f(x) = x^233 + x^74 + 1 (sect233 field used by the ECC datapath).
- Inverse of the squaring operator: sqrt(a) = a^(2^232), computed by repeated squaring, SQ_PER_CYC squarings per clock.
- Sits next to the operand select/register stage; consumes a 233-bit operand from it and returns a registered result with a start/done handshake, e.g. for point decompression and halving.

Parameters:
- M, 233, field degree (fixed; datapath width M bits, [232:0]).
- SQ_PER_CYC, 8, squarings per clock. Must divide 232; legal values 1, 2, 4, 8, 29.
- ITER, 232/SQ_PER_CYC, derived local constant: number of RUN cycles (29 at default).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset.
- start  input  1  request; sampled only when not busy.
- din  input  233  operand a, [232:0], bit i = coefficient of x^i; sampled with accepted start.
- busy  output  1  high while computation in progress.
- done  output  1  one-cycle pulse: dout valid and newly updated.
- dout  output  233  result sqrt(a), registered, holds until next completion.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (clk, rst). On rst: state=IDLE, busy=0, done=0, dout=0, counter=0, accumulator=0. Reset mid-RUN aborts; no done pulse; dout forced to 0.
- States: IDLE, RUN.
- IDLE: start=1 at edge -> acc<=din, cnt<=0, busy<=1, state<=RUN. start=0 -> stay. done<=0 on every edge except completion edge.
- RUN: each edge acc<=sq^SQ_PER_CYC(acc), cnt<=cnt+1. On edge where cnt==ITER-1: dout<=sq^SQ_PER_CYC(acc), done<=1, busy<=0, state<=IDLE.
- Latency: start sampled at edge 0 -> done high after edge ITER+1 ... precisely: load edge, then ITER RUN edges; done visible in the cycle after edge ITER+1 counted from start edge (30 edges at default; ITER+1 generally).
- start while busy=1: ignored, no queueing, din not sampled.
- start high in the same cycle done=1 (state is IDLE): accepted; back-to-back throughput one result per ITER+1 cycles.
- start held high continuously: restarts immediately each completion, din re-sampled at each acceptance.
- Squaring: bit-spread then reduction mod f(x); all results fully reduced, degree < 233; no unreduced state escapes.
- Counter width: ceil(log2(ITER)) bits, min 1; never wraps past ITER-1.
- din=0 -> dout=0; din=1 -> dout=1 (fixed points, same latency).

Decomposition:
- Shared package gf233_pkg: M, reduction tap positions (233, 74, 0), SQ_PER_CYC legality check, ITER, state encoding (IDLE/RUN).
- One sub-module: gf233_sq_chain, combinational, instantiates SQ_PER_CYC copies of the existing square block in series (DIN->DOUT chaining). Top keeps FSM, counter, acc, dout registers.

Test Plan:
- Reset during RUN (rst at cycle 10 after start, din=0x5A5A...) -> busy=0, done never pulses, dout=0; next start with din=1 -> dout=1 after ITER+1 cycles.
- din=4 (x^2) -> dout=2 (x); din=16 (x^4) -> dout=4; done exactly one cycle, busy high for ITER cycles.
- Round trip: 1000 random a, apply din=a^2 (golden model squaring mod f) -> dout=a; also sqrt(din)^2 == din for 1000 random din.
- start pulsed during RUN with different din -> ignored; dout matches first operand; no extra done.
- start held high 3 operations (din=2, then 4, then 16) -> three done pulses spaced ITER+1 cycles, results x^(sqrt) for 2 per model, 2, 4.
- Sweep SQ_PER_CYC in {1, 2, 4, 8, 29} -> identical results, latency ITER+1 = 233, 117, 59, 30, 9 cycles.
